// File: rtl/demux_deser8_pkg.sv
// Shared types and defaults for the serial-to-parallel demux deserializer.
package demux_deser8_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/demux_deser8_if.sv
// Control/data bundle between a serial bit source and the deserializer.
interface demux_deser8_if
  import demux_deser8_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  localparam int SW = $clog2(N);

  logic          start;
  logic          din;
  logic          din_valid;
  logic [N-1:0]  dout;
  logic          dout_valid;
  logic [SW-1:0] sel;
  logic          busy;
  logic          frame_err;

  modport master (
    output start, din, din_valid,
    input  dout, dout_valid, sel, busy, frame_err
  );

  modport slave (
    input  start, din, din_valid,
    output dout, dout_valid, sel, busy, frame_err
  );

endinterface

// File: rtl/demux_deser8_demux1toN.sv
// One-hot slot decoder: turns the current slot index into per-slot write enables.
module demux1toN #(
  parameter int N = 8
) (
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 en,
  output logic [N-1:0]         wen
);

  assign wen = en ? (N'(1) << sel) : '0;

endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel deserializer; states: IDLE | waiting for start,
// COLLECT | accepting qualified bits into the shadow word, LSB first.
module demux_deser8
  import demux_deser8_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic          clk,
  input logic          rst,
  demux_deser8_if.slave bus
);

  localparam int              SW       = $clog2(N);
  localparam logic [SW-1:0]   SEL_LAST = SW'(N - 1);

  state_t        state;
  logic [SW-1:0] sel;
  logic [N-1:0]  shadow;
  logic [N-1:0]  shadow_nxt;
  logic [N-1:0]  dout;
  logic [N-1:0]  wen;
  logic          dout_valid;
  logic          frame_err;
  logic          busy;
  logic          collecting;
  logic          last_bit;
  logic          restart;

  assign collecting = (state == COLLECT);
  assign last_bit   = collecting && bus.din_valid && (sel == SEL_LAST);
  // A start landing on the completing bit lets the frame finish instead of aborting it.
  assign restart    = collecting && bus.start && (sel != '0) && !last_bit;

  demux1toN #(.N(N)) u_demux (
    .sel (sel),
    .en  (collecting && bus.din_valid && !restart),
    .wen (wen)
  );

  assign shadow_nxt = (shadow & ~wen) | (wen & {N{bus.din}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= COLLECT;
            busy   <= 1'b1;
            sel    <= '0;
            shadow <= '0;
          end
        end
        COLLECT: begin
          if (restart) begin
            frame_err <= 1'b1;
            sel       <= '0;
            shadow    <= '0;
          end else if (bus.din_valid) begin
            if (last_bit) begin
              dout       <= shadow_nxt;
              dout_valid <= 1'b1;
              sel        <= '0;
              shadow     <= '0;
              if (!CONTINUOUS && !bus.start) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sel    <= sel + SW'(1);
              shadow <= shadow_nxt;
            end
          end
        end
      endcase
    end
  end

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.sel        = sel;
  assign bus.busy       = busy;
  assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_demux_deser8.sv
// Bench for demux_deser8: one-shot (dut0) and continuous (dut1) instances against a bit-count model.
module tb_demux_deser8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_deser8_if #(.N(8)) bus0 ();
  demux_deser8_if #(.N(8)) bus1 ();

  demux_deser8 #(.N(8), .CONTINUOUS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  demux_deser8 #(.N(8), .CONTINUOUS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: number of bits gathered so far, the bits themselves, last full word
  bit         mcont [2];
  bit         mbusy [2];
  bit         mdv   [2];
  bit         mfe   [2];
  int         mcnt  [2];
  logic [7:0] macc  [2];
  logic [7:0] mdout [2];

  function automatic logic [13:0] obs(int m);
    if (m == 0) return {bus0.dout, bus0.dout_valid, bus0.sel, bus0.busy, bus0.frame_err};
    return {bus1.dout, bus1.dout_valid, bus1.sel, bus1.busy, bus1.frame_err};
  endfunction

  function automatic logic [13:0] expv(int m);
    logic [2:0] c;
    c = 3'(mcnt[m]);
    return {mdout[m], mdv[m], c, mbusy[m], mfe[m]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mbusy[m] = 0; mdv[m] = 0; mfe[m] = 0;
      mcnt[m] = 0; macc[m] = '0; mdout[m] = '0;
    end
  endtask

  task automatic model_step(int m, bit s, bit d, bit v);
    bit last;
    mdv[m] = 0;
    mfe[m] = 0;
    if (!mbusy[m]) begin
      if (s) begin
        mbusy[m] = 1; mcnt[m] = 0; macc[m] = '0;
      end
    end else begin
      last = v && (mcnt[m] == 7);
      if (s && mcnt[m] != 0 && !last) begin
        mfe[m] = 1; mcnt[m] = 0; macc[m] = '0;
      end else if (v) begin
        macc[m][mcnt[m]] = d;
        mcnt[m]++;
        if (mcnt[m] == 8) begin
          mdout[m] = macc[m];
          mdv[m]   = 1;
          mcnt[m]  = 0;
          macc[m]  = '0;
          if (!mcont[m] && !s) mbusy[m] = 0;
        end
      end
    end
  endtask

  task automatic step(bit s0, bit d0, bit v0, bit s1, bit d1, bit v1);
    @(negedge clk);
    bus0.start = s0; bus0.din = d0; bus0.din_valid = v0;
    bus1.start = s1; bus1.din = d1; bus1.din_valid = v1;
    @(posedge clk);
    #1;
    cyc++;
    model_step(0, s0, d0, v0);
    model_step(1, s1, d1, v1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== 14'h0) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h want=%h", m, obs(m), 14'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 0, 1, 0, 0, 1);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== expv(m)) begin
        bad++;
        $display("FAIL reset_ignore_valid dut%0d got=%h want=%h", m, obs(m), expv(m));
      end
    end
  endtask

  task automatic test_normal();
    logic [7:0] w = 8'hD5;
    int pulses = 0;
    int at = -1;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, w[i], 1, 0, 0, 0);
      if (bus0.dout_valid) begin pulses++; at = i; end
      total++;
      if (obs(0) !== expv(0)) begin
        bad++;
        $display("FAIL normal_cycle bit%0d got=%h want=%h", i, obs(0), expv(0));
      end
    end
    step(0, 0, 0, 0, 0, 0);
    if (bus0.dout_valid) pulses++;
    total++;
    if (bus0.dout !== 8'hD5 || bus0.busy !== 1'b0) begin
      bad++;
      $display("FAIL normal_word dout=%h busy=%b want dout=d5 busy=0", bus0.dout, bus0.busy);
    end
    total++;
    if (pulses != 1 || at != 7) begin
      bad++;
      $display("FAIL normal_pulse pulses=%0d at=%0d want 1 at 7", pulses, at);
    end
  endtask

  task automatic test_gap();
    logic [7:0] w = 8'hD5;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      if (i >= 4 && i < 7) begin
        step(0, 1, 0, 0, 0, 0);
        total++;
        if (bus0.sel !== 3'd4 || bus0.dout_valid !== 1'b0) begin
          bad++;
          $display("FAIL gap_hold sel=%0d dv=%b want sel=4 dv=0", bus0.sel, bus0.dout_valid);
        end
      end else begin
        step(0, w[i < 4 ? i : i - 3], 1, 0, 0, 0);
        total++;
        if (obs(0) !== expv(0)) begin
          bad++;
          $display("FAIL gap_cycle i%0d got=%h want=%h", i, obs(0), expv(0));
        end
      end
    end
    total++;
    if (bus0.dout !== 8'hD5 || bus0.dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL gap_word dout=%h dv=%b want d5 1", bus0.dout, bus0.dout_valid);
    end
  endtask

  task automatic test_restart();
    logic [7:0] w = 8'hA5;
    int fe = 0;
    int dv = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'($urandom), 1, 0, 0, 0);
      dv += bus0.dout_valid;
    end
    step(1, 1, 1, 0, 0, 0);
    fe += bus0.frame_err;
    total++;
    if (obs(0) !== expv(0)) begin
      bad++;
      $display("FAIL restart_cycle got=%h want=%h", obs(0), expv(0));
    end
    for (int i = 0; i < 8; i++) begin
      step(0, w[i], 1, 0, 0, 0);
      fe += bus0.frame_err;
      dv += bus0.dout_valid;
    end
    total++;
    if (fe != 1 || dv != 1 || bus0.dout !== 8'hA5) begin
      bad++;
      $display("FAIL restart_result fe=%0d dv=%0d dout=%h want 1 1 a5", fe, dv, bus0.dout);
    end
  endtask

  task automatic test_continuous();
    logic [15:0] w = 16'hC33C;
    int t0 = -1;
    int t1 = -1;
    logic [7:0] v0 = '0;
    logic [7:0] v1 = '0;
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, w[i], 1);
      if (bus1.dout_valid) begin
        if (t0 < 0) begin t0 = i; v0 = bus1.dout; end
        else begin t1 = i; v1 = bus1.dout; end
      end
      total++;
      if (obs(1) !== expv(1) || bus1.busy !== 1'b1) begin
        bad++;
        $display("FAIL cont_cycle i%0d got=%h want=%h", i, obs(1), expv(1));
      end
    end
    total++;
    if (v0 !== 8'h3C || v1 !== 8'hC3 || t1 - t0 != 8) begin
      bad++;
      $display("FAIL cont_words got %h@%0d %h@%0d want 3c, c3 8 apart", v0, t0, v1, t1);
    end
  endtask

  task automatic test_async_reset();
    int dv = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    total++;
    if (bus0.sel !== 3'd5) begin
      bad++;
      $display("FAIL areset_presel sel=%0d want 5", bus0.sel);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== 14'h0) begin
        bad++;
        $display("FAIL areset_immediate dut%0d got=%h want=0", m, obs(m));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 0, 0);
      dv += bus0.dout_valid;
      total++;
      if (obs(0) !== expv(0) || bus0.frame_err !== 1'b0) begin
        bad++;
        $display("FAIL areset_frame i%0d got=%h want=%h", i, obs(0), expv(0));
      end
    end
    total++;
    if (bus0.dout !== 8'hFF || dv != 1) begin
      bad++;
      $display("FAIL areset_word dout=%h dv=%0d want ff 1", bus0.dout, dv);
    end
  endtask

  task automatic test_coincident();
    logic [7:0] w;
    w = 8'($urandom);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, w[i], 1, 0, 0, 0);
    step(1, w[7], 1, 0, 0, 0);
    total++;
    if (bus0.dout_valid !== 1'b1 || bus0.frame_err !== 1'b0 || bus0.sel !== 3'd0
        || bus0.busy !== 1'b1 || bus0.dout !== w) begin
      bad++;
      $display("FAIL coincident got dv=%b fe=%b sel=%0d busy=%b dout=%h want 1 0 0 1 %h",
               bus0.dout_valid, bus0.frame_err, bus0.sel, bus0.busy, bus0.dout, w);
    end
    step(0, 1, 1, 0, 0, 0);
    total++;
    if (obs(0) !== expv(0)) begin
      bad++;
      $display("FAIL coincident_next got=%h want=%h", obs(0), expv(0));
    end
  endtask

  task automatic test_random();
    bit s0, d0, v0, s1, d1, v1;
    for (int i = 0; i < 600; i++) begin
      s0 = ($urandom_range(0, 11) == 0);
      s1 = ($urandom_range(0, 11) == 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      d0 = 1'($urandom);
      d1 = 1'($urandom);
      step(s0, d0, v0, s1, d1, v1);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs(m) !== expv(m)) begin
          bad++;
          $display("FAIL random dut%0d cyc%0d got=%h want=%h", m, cyc, obs(m), expv(m));
        end
      end
    end
  endtask

  initial begin
    bus0.start = 0; bus0.din = 0; bus0.din_valid = 0;
    bus1.start = 0; bus1.din = 0; bus1.din_valid = 0;
    mcont[0] = 0;
    mcont[1] = 1;
    model_reset();
    test_reset();
    test_normal();
    test_gap();
    test_restart();
    test_continuous();
    test_async_reset();
    test_coincident();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
